// File: rtl/gate_response_checker.sv
// gate_response_checker: sweeps a/b into a gate bank, checks seven responses, reports verdict (option: GATE_CHK_STOP_ON_FAIL_EN)
module gate_response_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES = 1,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             out_and,
  input  logic             out_or,
  input  logic             out_not,
  input  logic             out_nand,
  input  logic             out_nor,
  input  logic             out_xor,
  input  logic             out_xnor,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [6:0]       fail_vec,
  output logic [1:0]       vec_idx
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int PW = $clog2(PASSES + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pass_cnt;
  logic [6:0] gold, mis;
  logic [ERR_W-1:0] err_nxt;
  logic settle_end, finish, stop;
  assign gold = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  assign mis = gold ^ {out_xnor, out_xor, out_nor, out_nand, out_not, out_or, out_and};
  assign settle_end = cnt == CW'(SETTLE_CYCLES - 1);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
  assign stop = |mis;
`else
  assign stop = 1'b0;
`endif
  assign finish = stop || (vec_idx == 2'd3 && pass_cnt == PW'(PASSES - 1));
  assign err_nxt = (|mis && err_count != '1) ? err_count + ERR_W'(1) : err_count;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next-state logic: settle, check one vector, then advance or finish
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = start ? SETTLE : IDLE;
      SETTLE:  state_n = settle_end ? CHECK : SETTLE;
      CHECK:   state_n = finish ? DONE : SETTLE;
      default: state_n = IDLE;
    endcase
  end
  // stimulus, counters and verdict registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a <= 1'b0;
      b <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      fail_vec <= '0;
      vec_idx <= '0;
      cnt <= '0;
      pass_cnt <= '0;
    end else begin
      busy <= state_n == SETTLE || state_n == CHECK;
      done <= state_n == DONE;
      case (state)
        IDLE: if (start) begin
          vec_idx <= '0;
          a <= 1'b0;
          b <= 1'b0;
          cnt <= '0;
          pass_cnt <= '0;
          err_count <= '0;
          fail_vec <= '0;
          pass <= 1'b0;
        end
        SETTLE: cnt <= settle_end ? '0 : cnt + CW'(1);
        CHECK: begin
          fail_vec <= fail_vec | mis;
          err_count <= err_nxt;
          if (finish) begin
            pass <= err_nxt == '0;
            a <= 1'b0;
            b <= 1'b0;
          end else if (vec_idx != 2'd3) begin
            vec_idx <= vec_idx + 2'd1;
            {a, b} <= vec_idx + 2'd1;
          end else begin
            vec_idx <= '0;
            {a, b} <= 2'b00;
            pass_cnt <= pass_cnt + PW'(1);
          end
        end
        default: ;
      endcase
    end
endmodule
